serial_adder: RTL and testbench

//  Bit-serial adder: the additive counterpart of the full subtractor datapath.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_full_adder.sv | 18 +
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the ceiling-log2 used to size the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= value; callers pass value >= 2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder; the only arithmetic cell in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  always_comb begin
    half = a ^ b;
    sum  = half ^ cin;
    cout = (a & b) | (cin & half);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin LSB first through one full_adder cell,
// presenting the result, carry out and signed overflow after WIDTH bit edges.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int               CNT_W    = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Handshake: start is accepted on any edge where the FSM is in IDLE or DONE
  // (that edge captures a/b/cin); while busy is high start is ignored, and
  // done is a single-cycle pulse during which sum/cout/overflow are valid
  // (they stay held until the next completion).

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH:0]   ps_wide;

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    ps_wide = {fa_s, ps_q};

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          ps_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        ps_d    = ps_wide[WIDTH:1];
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          sum_d   = ps_wide[WIDTH:1];
          cout_d  = fa_co;
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ fa_co;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    overflow  = ovf_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 instance checked every cycle against an
// arithmetic model, plus a WIDTH=1 instance checked exhaustively.
module tb_serial_adder;
  import serial_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // ---------------- WIDTH=8 DUT ----------------
  logic       w8_start = 1'b0;
  logic [7:0] w8_a = '0, w8_b = '0;
  logic       w8_cin = 1'b0;
  logic       w8_busy, w8_done, w8_cout, w8_ovf;
  logic [7:0] w8_sum;
  logic [1:0] w8_state;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(w8_start), .a(w8_a), .b(w8_b), .cin(w8_cin),
    .busy(w8_busy), .done(w8_done), .sum(w8_sum), .cout(w8_cout),
    .overflow(w8_ovf), .dbg_state(w8_state)
  );

  // ---------------- WIDTH=1 DUT ----------------
  logic       w1_start = 1'b0;
  logic [0:0] w1_a = '0, w1_b = '0;
  logic       w1_cin = 1'b0;
  logic       w1_busy, w1_done, w1_cout, w1_ovf;
  logic [0:0] w1_sum;
  logic [1:0] w1_state;

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(w1_start), .a(w1_a), .b(w1_b), .cin(w1_cin),
    .busy(w1_busy), .done(w1_done), .sum(w1_sum), .cout(w1_cout),
    .overflow(w1_ovf), .dbg_state(w1_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of an 8-bit add as {overflow, cout, sum}, from plain integer arithmetic.
  function automatic logic [9:0] model_result(input logic [7:0] x, input logic [7:0] y, input logic c);
    int u, s;
    logic [9:0] r;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    r[7:0] = u[7:0];
    r[8]   = (u > 255);
    r[9]   = (s > 127) || (s < -128);
    return r;
  endfunction

  // ---------------- model + scoreboard (WIDTH=8) ----------------
  logic [9:0] exp_q[$];
  bit         m_busy = 1'b0, m_done = 1'b0;
  int         m_rem  = 0;
  logic [7:0] m_sum  = '0;
  logic       m_cout = 1'b0, m_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0;
      m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      exp_q.delete();
    end else if (!m_busy && w8_start) begin
      exp_q.push_back(model_result(w8_a, w8_b, w8_cin));
      m_busy <= 1'b1; m_done <= 1'b0; m_rem <= 8;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        {m_ovf, m_cout, m_sum} <= exp_q.pop_front();
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     32'(w8_busy), 32'(m_busy));
      check("done",     32'(w8_done), 32'(m_done));
      check("sum",      32'(w8_sum),  32'(m_sum));
      check("cout",     32'(w8_cout), 32'(m_cout));
      check("overflow", 32'(w8_ovf),  32'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic c);
    w8_a = x; w8_b = y; w8_cin = c; w8_start = 1'b1;
    tick();
    w8_start = 1'b0;
    w8_a = 8'($urandom_range(0, 255));
    w8_b = 8'($urandom_range(0, 255));
    w8_cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int budget, output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    while (edges < budget && !ok) begin
      tick();
      edges++;
      if (w8_done) ok = 1'b1;
    end
    check("done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic [7:0] e_sum, input logic e_cout,
                        input logic e_ovf);
    int edges;
    bit ok;
    start_op(x, y, c);
    wait_done(20, edges, ok);
    check({name, "_latency"}, 32'(edges), 32'd8);
    check({name, "_sum"},     32'(w8_sum),  32'(e_sum));
    check({name, "_cout"},    32'(w8_cout), 32'(e_cout));
    check({name, "_ovf"},     32'(w8_ovf),  32'(e_ovf));
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  edges;
    int  pulses;
    bit  ok;
    logic [2:0] v;
    logic [1:0] u1;
    bit  e_ovf1;

    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_busy",  32'(w8_busy),  32'd0);
    check("rst_done",  32'(w8_done),  32'd0);
    check("rst_sum",   32'(w8_sum),   32'd0);
    check("rst_state", 32'(w8_state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // Directed arithmetic vectors.
    run_op("t1_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("t2_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("t2_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("t3_00_00", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_op("t3_7f_00", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

    // Start pulsed at bit-edge 3 is ignored.
    start_op(8'h11, 8'h22, 1'b0);
    tick(); tick();
    w8_a = 8'hEE; w8_b = 8'hEE; w8_start = 1'b1;
    tick();
    w8_start = 1'b0;
    wait_done(20, edges, ok);
    check("t4_ignored_latency", 32'(edges), 32'd5);
    check("t4_ignored_sum", 32'(w8_sum), 32'h33);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (w8_done) pulses++;
    end
    check("t4_extra_done", 32'(pulses), 32'd0);

    // Start held through the run and the DONE cycle: back-to-back op.
    w8_a = 8'h40; w8_b = 8'h41; w8_cin = 1'b1; w8_start = 1'b1;
    tick();
    w8_a = 8'h0F; w8_b = 8'hF0; w8_cin = 1'b1;
    wait_done(20, edges, ok);
    check("t4_b2b_first_sum", 32'(w8_sum), 32'h82);
    check("t4_b2b_first_ovf", 32'(w8_ovf), 32'd1);
    tick();
    w8_start = 1'b0;
    check("t4_b2b_busy_gap", 32'(w8_busy), 32'd1);
    check("t4_b2b_done_drop", 32'(w8_done), 32'd0);
    wait_done(20, edges, ok);
    check("t4_b2b_second_latency", 32'(edges), 32'd8);
    check("t4_b2b_second_sum",  32'(w8_sum),  32'h00);
    check("t4_b2b_second_cout", 32'(w8_cout), 32'd1);
    tick();

    // Reset at bit-edge 4 aborts the op.
    start_op(8'h9C, 8'hA5, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("t5_rst_busy", 32'(w8_busy), 32'd0);
    check("t5_rst_done", 32'(w8_done), 32'd0);
    check("t5_rst_sum",  32'(w8_sum),  32'd0);
    check("t5_rst_cout", 32'(w8_cout), 32'd0);
    check("t5_rst_ovf",  32'(w8_ovf),  32'd0);
    rst = 1'b0;
    tick();
    run_op("t5_fresh", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // Random sweep; the per-cycle model does the checking.
    for (int i = 0; i < 1000; i++) begin
      start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)));
      wait_done(20, edges, ok);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // WIDTH=1 instance: all operand combinations.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      w1_a = v[2]; w1_b = v[1]; w1_cin = v[0]; w1_start = 1'b1;
      tick();
      w1_start = 1'b0;
      check("w1_busy", 32'(w1_busy), 32'd1);
      tick();
      u1 = 2'(int'(v[2]) + int'(v[1]) + int'(v[0]));
      e_ovf1 = ((v[0] ? 1 : 0) - (v[2] ? 1 : 0) - (v[1] ? 1 : 0)) > 0 ||
               ((v[0] ? 1 : 0) - (v[2] ? 1 : 0) - (v[1] ? 1 : 0)) < -1;
      check("w1_done", 32'(w1_done), 32'd1);
      check("w1_sum",  32'(w1_sum),  32'(u1[0]));
      check("w1_cout", 32'(w1_cout), 32'(u1[1]));
      check("w1_ovf",  32'(w1_ovf),  32'(e_ovf1));
      tick();
    end
    w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_start = 1'b1;
    tick();
    w1_start = 1'b0;
    tick();
    check("t6_w1_111_sum",  32'(w1_sum),  32'd1);
    check("t6_w1_111_cout", 32'(w1_cout), 32'd1);
    check("t6_w1_111_ovf",  32'(w1_ovf),  32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
